// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL relock sequencer: channel FSM states, write-data
// field layout and the per-channel configuration captured on a write.
package pll_seq_pkg;

  localparam int unsigned CFG_RATIO_MAX_W = 16;
  localparam int unsigned DATA_EXT_W      = 32;
  localparam int unsigned DATA_EN_BIT     = 0;
  localparam int unsigned DATA_VCODIV_LSB = 1;
  localparam int unsigned DATA_RATIO_LSB  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISABLE,
    ST_APPLY,
    ST_ENABLE,
    ST_LOCKED,
    ST_FAULT
  } seq_state_e;

  typedef struct packed {
    logic                       enable;
    logic [1:0]                 vcodiv;
    logic [CFG_RATIO_MAX_W-1:0] ratio;
  } chan_cfg_t;

  // Split a zero-extended write word into its fields; ratio masked to ratio_w bits.
  function automatic chan_cfg_t unpack_cfg(input logic [DATA_EXT_W-1:0] d,
                                           input int unsigned ratio_w);
    chan_cfg_t c;
    logic [DATA_EXT_W-1:0] mask;
    mask     = (DATA_EXT_W'(1) << ratio_w) - DATA_EXT_W'(1);
    c.enable = d[DATA_EN_BIT];
    c.vcodiv = d[DATA_VCODIV_LSB +: 2];
    c.ratio  = CFG_RATIO_MAX_W'((d >> DATA_RATIO_LSB) & mask);
    return c;
  endfunction

endpackage

// File: rtl/pll_chan_seq.sv
// One PLL channel: lock synchroniser, relock FSM, off/lock timers and retry
// counter. All outputs are registered.
// Optional: PLL_AUTO_RELOCK_EN makes a lost lock restart the relock sequence.
module pll_chan_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned          RATIO_W      = 10,
  parameter logic [RATIO_W-1:0]   RESET_RATIO  = 'h19,
  parameter int unsigned          OFF_CYCLES   = 16,
  parameter int unsigned          LOCK_TIMEOUT = 65535,
  parameter int unsigned          RETRY_MAX    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  chan_cfg_t          cfg,
  input  logic               lock,
  output logic               pll_en,
  output logic [RATIO_W-1:0] pll_ratio,
  output logic [1:0]         pll_vcodiv,
  output logic               busy,
  output logic               locked,
  output logic               fault,
  output logic               lost_lock
);

  localparam int unsigned OFF_W = (OFF_CYCLES   > 1) ? $clog2(OFF_CYCLES + 1)   : 1;
  localparam int unsigned TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int unsigned RTY_W = (RETRY_MAX    > 1) ? $clog2(RETRY_MAX + 1)    : 1;

  seq_state_e         state_q,   state_d;
  logic [OFF_W-1:0]   off_cnt_q, off_cnt_d;
  logic [TMR_W-1:0]   tmr_q,     tmr_d;
  logic [RTY_W-1:0]   rty_q,     rty_d;
  chan_cfg_t          cfg_q,     cfg_d;
  logic               sync1_q,   sync1_d;
  logic               lock_s_q,  lock_s_d;
  logic               pll_en_q,  pll_en_d;
  logic [RATIO_W-1:0] ratio_q,   ratio_d;
  logic [1:0]         vcodiv_q,  vcodiv_d;
  logic               busy_q,    busy_d;
  logic               locked_q,  locked_d;
  logic               fault_q,   fault_d;
  logic               lost_q,    lost_d;

  logic cfg_unused;
  assign cfg_unused = ^cfg_q;

  // Next-state and registered-output logic; status outputs follow the next state.
  always_comb begin
    state_d   = state_q;
    off_cnt_d = off_cnt_q;
    tmr_d     = tmr_q;
    rty_d     = rty_q;
    cfg_d     = cfg_q;
    ratio_d   = ratio_q;
    vcodiv_d  = vcodiv_q;
    lost_d    = lost_q;
    sync1_d   = lock;
    lock_s_d  = sync1_q;

    unique case (state_q)
      ST_IDLE, ST_LOCKED, ST_FAULT: begin
        if (wr) begin
          state_d   = ST_DISABLE;
          cfg_d     = cfg;
          lost_d    = 1'b0;
          rty_d     = '0;
          off_cnt_d = '0;
        end else if (state_q == ST_LOCKED && !lock_s_q) begin
          lost_d = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
          state_d   = ST_DISABLE;
          off_cnt_d = '0;
          rty_d     = '0;
`endif
        end
      end
      ST_DISABLE: begin
        if (off_cnt_q == OFF_W'(OFF_CYCLES - 1)) begin
          state_d  = ST_APPLY;
          ratio_d  = cfg_q.ratio[RATIO_W-1:0];
          vcodiv_d = cfg_q.vcodiv;
        end else begin
          off_cnt_d = off_cnt_q + OFF_W'(1);
        end
      end
      ST_APPLY: begin
        // A disable write still passes through APPLY so the outputs track it.
        state_d = cfg_q.enable ? ST_ENABLE : ST_IDLE;
        tmr_d   = '0;
      end
      ST_ENABLE: begin
        // Lock is checked before the timeout so a coincident lock wins.
        if (lock_s_q) begin
          state_d = ST_LOCKED;
        end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          if (rty_q < RTY_W'(RETRY_MAX)) begin
            rty_d     = rty_q + RTY_W'(1);
            off_cnt_d = '0;
            state_d   = ST_DISABLE;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pll_en_d = (state_d == ST_ENABLE) || (state_d == ST_LOCKED);
    busy_d   = (state_d == ST_DISABLE) || (state_d == ST_APPLY) || (state_d == ST_ENABLE);
    locked_d = (state_d == ST_LOCKED);
    fault_d  = (state_d == ST_FAULT);
  end

  // State, counters, synchroniser and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      off_cnt_q <= '0;
      tmr_q     <= '0;
      rty_q     <= '0;
      cfg_q     <= '0;
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      pll_en_q  <= 1'b0;
      ratio_q   <= RESET_RATIO;
      vcodiv_q  <= '0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_cnt_q <= off_cnt_d;
      tmr_q     <= tmr_d;
      rty_q     <= rty_d;
      cfg_q     <= cfg_d;
      sync1_q   <= sync1_d;
      lock_s_q  <= lock_s_d;
      pll_en_q  <= pll_en_d;
      ratio_q   <= ratio_d;
      vcodiv_q  <= vcodiv_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      fault_q   <= fault_d;
      lost_q    <= lost_d;
    end
  end

  assign pll_en     = pll_en_q;
  assign pll_ratio  = ratio_q;
  assign pll_vcodiv = vcodiv_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign fault      = fault_q;
  assign lost_lock  = lost_q;

endmodule

// File: rtl/pll_relock_seq.sv
// Multi-channel PLL relock sequencer: write decode, ready mux, address error
// flag and NUM_PLL pll_chan_seq channels.
// Optional: PLL_AUTO_RELOCK_EN (applies inside pll_chan_seq).
module pll_relock_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned        NUM_PLL      = 2,
  parameter int unsigned        ADDR_W       = 4,
  parameter int unsigned        DATA_W       = 16,
  parameter int unsigned        RATIO_W      = 10,
  parameter logic [RATIO_W-1:0] RESET_RATIO  = 'h19,
  parameter int unsigned        OFF_CYCLES   = 16,
  parameter int unsigned        LOCK_TIMEOUT = 65535,
  parameter int unsigned        RETRY_MAX    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  output logic                       ready,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data,
  input  logic [NUM_PLL-1:0]         lock,
  output logic [NUM_PLL-1:0]         pll_en,
  output logic [NUM_PLL*RATIO_W-1:0] pll_ratio,
  output logic [NUM_PLL*2-1:0]       pll_vcodiv,
  output logic [NUM_PLL-1:0]         busy,
  output logic [NUM_PLL-1:0]         locked,
  output logic [NUM_PLL-1:0]         fault,
  output logic [NUM_PLL-1:0]         lost_lock,
  output logic                       addr_err
);

  logic [DATA_EXT_W-1:0] data_ext;
  logic [31:0]           addr_ext;
  chan_cfg_t             wr_cfg;
  logic                  data_unused;
  logic                  ready_c;
  logic                  addr_ok;
  logic [NUM_PLL-1:0]    wr_c;
  logic                  addr_err_q, addr_err_d;

  assign data_ext    = DATA_EXT_W'(data);
  assign addr_ext    = 32'(address);
  assign wr_cfg      = unpack_cfg(data_ext, RATIO_W);
  assign data_unused = ^data_ext;

  // Address decode: invalid addresses are always ready and only raise addr_err.
  always_comb begin
    ready_c = 1'b1;
    addr_ok = 1'b0;
    wr_c    = '0;
    for (int unsigned i = 0; i < NUM_PLL; i++) begin
      if (addr_ext == i) begin
        addr_ok = 1'b1;
        ready_c = !busy[i];
      end
    end
    for (int unsigned i = 0; i < NUM_PLL; i++) begin
      wr_c[i] = valid && ready_c && (addr_ext == i);
    end
    addr_err_d = addr_err_q | (valid & ~addr_ok);
  end

  // Sticky address error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= addr_err_d;
  end

  assign ready    = ready_c;
  assign addr_err = addr_err_q;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
    pll_chan_seq #(
      .RATIO_W      (RATIO_W),
      .RESET_RATIO  (RESET_RATIO),
      .OFF_CYCLES   (OFF_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .RETRY_MAX    (RETRY_MAX)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr_c[g]),
      .cfg        (wr_cfg),
      .lock       (lock[g]),
      .pll_en     (pll_en[g]),
      .pll_ratio  (pll_ratio[g*RATIO_W +: RATIO_W]),
      .pll_vcodiv (pll_vcodiv[g*2 +: 2]),
      .busy       (busy[g]),
      .locked     (locked[g]),
      .fault      (fault[g]),
      .lost_lock  (lost_lock[g])
    );
  end

endmodule

// File: tb/tb_pll_relock_seq.sv
// Self-checking bench for pll_relock_seq: directed scenarios then randomized
// writes/lock behaviour against a timeline-based reference model.
module tb_pll_relock_seq;

  localparam int NP  = 2;
  localparam int OFF = 16;
  localparam int LT  = 50;
  localparam int RM  = 3;
  localparam int RW  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic              ready;
  logic [3:0]        address;
  logic [15:0]       data;
  logic [NP-1:0]     lock;
  logic [NP-1:0]     pll_en;
  logic [NP*RW-1:0]  pll_ratio;
  logic [NP*2-1:0]   pll_vcodiv;
  logic [NP-1:0]     busy, locked, fault, lost_lock;
  logic              addr_err;

  pll_relock_seq #(
    .NUM_PLL(NP), .ADDR_W(4), .DATA_W(16), .RATIO_W(RW), .RESET_RATIO(10'h19),
    .OFF_CYCLES(OFF), .LOCK_TIMEOUT(LT), .RETRY_MAX(RM)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .address(address),
    .data(data), .lock(lock), .pll_en(pll_en), .pll_ratio(pll_ratio),
    .pll_vcodiv(pll_vcodiv), .busy(busy), .locked(locked), .fault(fault),
    .lost_lock(lost_lock), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit last_acc;
  bit lock_auto;

  // Reference model: an active channel walks a timeline seq (0..OFF-1 off,
  // OFF apply, >OFF enable window); outside it, it is idle, locked or faulted.
  bit m_active[NP];
  int m_seq[NP];
  int m_rty[NP];
  bit m_cfg_en[NP];
  int m_cfg_ratio[NP], m_cfg_vco[NP];
  int m_ratio[NP], m_vco[NP];
  bit m_locked[NP], m_fault[NP], m_lost[NP];
  bit s1[NP], s2[NP];
  bit m_addr_err;

  int en_cnt[NP], lk_delay[NP], drop_cnt[NP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit m_en(input int ch);
    return (m_active[ch] && m_seq[ch] > OFF) || m_locked[ch];
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NP; ch++) begin
      m_active[ch] = 0; m_seq[ch] = 0; m_rty[ch] = 0; m_cfg_en[ch] = 0;
      m_cfg_ratio[ch] = 0; m_cfg_vco[ch] = 0; m_ratio[ch] = 'h19; m_vco[ch] = 0;
      m_locked[ch] = 0; m_fault[ch] = 0; m_lost[ch] = 0; s1[ch] = 0; s2[ch] = 0;
    end
    m_addr_err = 0;
  endtask

  task automatic model_step();
    int a;
    bit ls;
    last_acc = 0;
    if (rst) begin
      model_reset();
      return;
    end
    a = -1;
    if (valid) begin
      if (int'(address) >= NP) begin
        m_addr_err = 1;
        last_acc   = 1;
      end else if (!m_active[int'(address)]) begin
        a = int'(address);
        last_acc = 1;
      end
    end
    for (int ch = 0; ch < NP; ch++) begin
      ls = s2[ch]; s2[ch] = s1[ch]; s1[ch] = lock[ch];
      if (ch == a) begin
        m_active[ch] = 1; m_seq[ch] = 0; m_rty[ch] = 0;
        m_cfg_en[ch]    = data[0];
        m_cfg_vco[ch]   = int'(data[2:1]);
        m_cfg_ratio[ch] = int'(data[12:3]);
        m_locked[ch] = 0; m_fault[ch] = 0; m_lost[ch] = 0;
      end else if (m_active[ch]) begin
        if (m_seq[ch] < OFF - 1) m_seq[ch]++;
        else if (m_seq[ch] == OFF - 1) begin
          m_seq[ch] = OFF; m_ratio[ch] = m_cfg_ratio[ch]; m_vco[ch] = m_cfg_vco[ch];
        end else if (m_seq[ch] == OFF) begin
          if (m_cfg_en[ch]) m_seq[ch]++;
          else m_active[ch] = 0;
        end else begin
          if (ls) begin
            m_active[ch] = 0; m_locked[ch] = 1;
          end else if (m_seq[ch] - OFF - 1 == LT - 1) begin
            if (m_rty[ch] < RM) begin m_rty[ch]++; m_seq[ch] = 0; end
            else begin m_active[ch] = 0; m_fault[ch] = 1; end
          end else m_seq[ch]++;
        end
      end else if (m_locked[ch] && !ls) begin
        m_lost[ch] = 1;
`ifdef PLL_AUTO_RELOCK_EN
        m_locked[ch] = 0; m_active[ch] = 1; m_seq[ch] = 0; m_rty[ch] = 0;
`endif
      end
    end
  endtask

  task automatic compare_all();
    for (int ch = 0; ch < NP; ch++) begin
      check($sformatf("pll_en%0d", ch),   32'(pll_en[ch]),              32'(m_en(ch)));
      check($sformatf("ratio%0d", ch),    32'(pll_ratio[ch*RW +: RW]),  32'(m_ratio[ch]));
      check($sformatf("vcodiv%0d", ch),   32'(pll_vcodiv[ch*2 +: 2]),   32'(m_vco[ch]));
      check($sformatf("busy%0d", ch),     32'(busy[ch]),                32'(m_active[ch]));
      check($sformatf("locked%0d", ch),   32'(locked[ch]),              32'(m_locked[ch]));
      check($sformatf("fault%0d", ch),    32'(fault[ch]),               32'(m_fault[ch]));
      check($sformatf("lost_lock%0d", ch),32'(lost_lock[ch]),           32'(m_lost[ch]));
    end
    check("addr_err", 32'(addr_err), 32'(m_addr_err));
  endtask

  task automatic update_lock();
    for (int ch = 0; ch < NP; ch++) begin
      if (m_en(ch)) en_cnt[ch]++;
      else begin en_cnt[ch] = 0; lk_delay[ch] = $urandom_range(0, 70); end
      if (drop_cnt[ch] > 0) drop_cnt[ch]--;
      else if (lock[ch] && $urandom_range(0, 299) == 0) drop_cnt[ch] = $urandom_range(1, 8);
      lock[ch] = (en_cnt[ch] > lk_delay[ch]) && (drop_cnt[ch] == 0);
    end
  endtask

  task automatic tick();
    bit exp_ready;
    @(negedge clk);
    exp_ready = (int'(address) >= NP) ? 1'b1 : !m_active[int'(address)];
    check("ready", 32'(ready), 32'(exp_ready));
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    compare_all();
    if (lock_auto) update_lock();
  endtask

  task automatic do_write(input int a, input logic [15:0] d, input int budget, output int waited);
    valid = 1; address = 4'(a); data = d; waited = 0;
    while (waited < budget) begin
      tick();
      waited++;
      if (last_acc) break;
    end
    check($sformatf("wr_accept_a%0d", a), 32'(last_acc), 32'd1);
    valid = 0;
  endtask

  function automatic logic [15:0] mk_data(input int ratio, input int vco, input bit en);
    return 16'((ratio << 3) | (vco << 1) | int'(en));
  endfunction

  initial begin
    int w, t_acc, k, en_hi;
    rst = 1; valid = 0; address = 0; data = 0; lock = '0; lock_auto = 0;
    for (int ch = 0; ch < NP; ch++) begin en_cnt[ch] = 0; lk_delay[ch] = 0; drop_cnt[ch] = 0; end
    model_reset();
    repeat (3) tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ratio0", 32'(pll_ratio[RW-1:0]), 32'h19);
    rst = 0;
    tick();

    // 1: basic relock on ch0
    do_write(0, mk_data('h19, 2, 1), 5, w);
    t_acc = cyc;
    k = 0;
    while (k < 60 && pll_en[0] !== 1'b1) begin tick(); k++; end
    check("t1_en_delay", 32'(cyc - t_acc), 32'(OFF + 1));
    repeat (30) tick();
    lock[0] = 1;
    repeat (5) tick();
    check("t1_locked", 32'(locked[0]), 32'd1);

    // 2: ch1 never locks -> four windows then fault
    do_write(1, mk_data('h2A3, 1, 1), 5, w);
    en_hi = 0; k = 0;
    while (k < 400 && !m_fault[1]) begin
      tick(); k++;
      if (pll_en[1] === 1'b1) en_hi++;
    end
    check("t2_fault", 32'(fault[1]), 32'd1);
    check("t2_en_cycles", 32'(en_hi), 32'(4 * LT));

    // 3: back-to-back write to a busy channel stalls; other channel goes through
    do_write(0, mk_data('h0F3, 1, 1), 5, w);
    valid = 1; address = 0; data = mk_data('h111, 3, 1);
    repeat (5) tick();
    check("t3_ready_busy", 32'(ready), 32'd0);
    valid = 0;
    do_write(1, mk_data('h0AA, 0, 1), 5, w);
    check("t3_ch1_wait", 32'(w), 32'd1);
    do_write(0, mk_data('h111, 3, 1), 100, w);
    repeat (25) tick();

    // 4: lock drop while locked
    lock[0] = 0;
    repeat (10) tick();
    lock[0] = 1;
    repeat (5) tick();
    check("t4_lost", 32'(lost_lock[0]), 32'd1);
    repeat (30) tick();

    // 5: invalid address
    do_write(7, 16'hFFFF, 2, w);
    check("t5_wait", 32'(w), 32'd1);
    check("t5_addr_err", 32'(addr_err), 32'd1);

    // 6: reset during ENABLE
    lock[0] = 0;
    repeat (6) tick();
    do_write(0, mk_data('h155, 2, 1), 5, w);
    repeat (OFF + 5) tick();
    check("t6_en_before", 32'(pll_en[0]), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_en", 32'(pll_en[0]), 32'd0);
    check("t6_ratio", 32'(pll_ratio[RW-1:0]), 32'h19);
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    tick();

    // Randomized traffic with model-driven lock behaviour
    lock_auto = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!valid && $urandom_range(0, 5) == 0) begin
        valid = 1;
        address = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(NP, 15))
                                              : 4'($urandom_range(0, NP - 1));
        data = 16'($urandom);
        if ($urandom_range(0, 3) != 0) data[0] = 1'b1;
      end
      rst = ($urandom_range(0, 1499) == 0);
      tick();
      if (last_acc) valid = 0;
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
